// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer.
//   state_t                    : debounce FSM states
//   DEBOUNCE_CYCLES_50MHZ_20MS : 20 ms qualification window at a 50 MHz clock
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // stable released
    PRESS_WAIT   = 2'd1,  // qualifying a press
    PRESSED      = 2'd2,  // stable pressed
    RELEASE_WAIT = 2'd3   // qualifying a release
  } state_t;

  localparam int unsigned DEBOUNCE_CYCLES_50MHZ_20MS = 1_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: synchronizes a bouncing mechanical key, qualifies every
// level change over DEBOUNCE_CYCLES consecutive stable samples and emits a
// registered level plus single-cycle press/release pulses.
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   key_in      : raw key, asynchronous to clk
//   key_level   : debounced state, 1 = pressed (registered)
//   key_press   : one-cycle pulse on an accepted press (registered)
//   key_release : one-cycle pulse on an accepted release (registered)
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_20MS,
  parameter logic        KEY_ACTIVE      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q;
  logic          s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_next, press_next, release_next;

  // Synchronizer resets to the released raw level so reset never looks
  // like a held key.
  sync_2ff #(
    .RST_VAL(~KEY_ACTIVE)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (key_in),
    .q    (sync_q)
  );

  // Normalize polarity: s = 1 means pressed.
  assign s = (sync_q == KEY_ACTIVE);

  // State register, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
    end
  end

  // Next-state and counter logic. The counter restarts on every bounce and
  // stops at CNT_MAX, so it can never wrap.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_MAX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode of the accepted transitions, captured into the output
  // registers on the same edge that commits the state change.
  always_comb begin
    press_next   = (state_reg == PRESS_WAIT)   &&  s && (cnt_reg == CNT_MAX);
    release_next = (state_reg == RELEASE_WAIT) && !s && (cnt_reg == CNT_MAX);
    level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=8, KEY_ACTIVE=1.
// Inputs change 1 ns after a rising edge, so the following edge is the first
// sampling edge (edge 1); an accepted transition is visible after edge 11.
module tb_key_debounce;
  import key_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_level, key_press, key_release;

  int n_vec = 0;
  int n_bad = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(8),
    .KEY_ACTIVE     (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n edges, sampling 1 ns after each; report pulse counts, overlap
  // count and the edge index (1-based) of the first press/release pulse.
  task automatic run(input int n, output int np, output int nr, output int nov,
                     output int fp, output int fr);
    np = 0; nr = 0; nov = 0; fp = 0; fr = 0;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (key_press) begin
        np++;
        if (fp == 0) fp = e;
      end
      if (key_release) begin
        nr++;
        if (fr == 0) fr = e;
      end
      if (key_press && key_release) nov++;
    end
  endtask

  int np, nr, nov, fp, fr;
  int tp, tr, tov;

  initial begin
    rst_n  = 1'b0;
    key_in = 1'b0;
    #12;
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_release", key_release, 0);
    check("rst_state", int'(dut.state_reg), int'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(5, np, nr, nov, fp, fr);
    check("idle_level", key_level, 0);

    // clean press
    key_in = 1'b1;
    run(30, np, nr, nov, fp, fr);
    check("clean_press_edge", fp, 11);
    check("clean_press_cnt", np, 1);
    check("clean_press_norel", nr, 0);
    check("clean_press_level", key_level, 1);

    // clean release
    key_in = 1'b0;
    run(30, np, nr, nov, fp, fr);
    check("clean_rel_edge", fr, 11);
    check("clean_rel_cnt", nr, 1);
    check("clean_rel_nopress", np, 0);
    check("clean_rel_level", key_level, 0);

    // bouncy press: toggle every 3 cycles for 24 cycles, then hold 1
    tp = 0; tr = 0;
    for (int i = 0; i < 8; i++) begin
      key_in = (i % 2 == 0);
      run(3, np, nr, nov, fp, fr);
      tp += np; tr += nr;
    end
    check("bounce_nopulse", tp, 0);
    check("bounce_level", key_level, 0);
    key_in = 1'b1;
    run(30, np, nr, nov, fp, fr);
    check("bounce_press_edge", fp, 11);
    check("bounce_press_cnt", np + tp, 1);
    check("bounce_norel", nr + tr, 0);
    check("bounce_level_hi", key_level, 1);

    // bouncy release: 0,1,0,1 for 2 cycles each, then hold 0
    tp = 0; tr = 0;
    for (int i = 0; i < 4; i++) begin
      key_in = (i % 2 == 1);
      run(2, np, nr, nov, fp, fr);
      tp += np; tr += nr;
    end
    check("relb_nopulse", tr, 0);
    check("relb_level_hold", key_level, 1);
    key_in = 1'b0;
    run(30, np, nr, nov, fp, fr);
    check("relb_rel_edge", fr, 11);
    check("relb_rel_cnt", nr + tr, 1);
    check("relb_nopress", np + tp, 0);
    check("relb_level", key_level, 0);

    // glitch shorter than the window
    key_in = 1'b1;
    run(5, np, nr, nov, fp, fr);
    tp = np;
    key_in = 1'b0;
    run(30, np, nr, nov, fp, fr);
    check("glitch_nopress", np + tp, 0);
    check("glitch_level", key_level, 0);
    check("glitch_state", int'(dut.state_reg), int'(IDLE));

    // reset in the middle of press qualification (cnt=5 after edge 8)
    key_in = 1'b1;
    run(8, np, nr, nov, fp, fr);
    check("midq_state", int'(dut.state_reg), int'(PRESS_WAIT));
    check("midq_cnt", dut.cnt_reg, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("midq_rst_state", int'(dut.state_reg), int'(IDLE));
    check("midq_rst_cnt", dut.cnt_reg, 0);
    check("midq_rst_press", key_press, 0);
    check("midq_rst_level", key_level, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(30, np, nr, nov, fp, fr);
    check("midq_press_edge", fp, 11);
    check("midq_press_cnt", np, 1);
    check("midq_level", key_level, 1);

    // asynchronous reset while pressed clears key_level before any edge
    #3;
    rst_n = 1'b0;
    #1;
    check("pressed_rst_level", key_level, 0);
    check("pressed_rst_state", int'(dut.state_reg), int'(IDLE));
    @(posedge clk); #1;
    key_in = 1'b0;
    rst_n  = 1'b1;
    run(30, np, nr, nov, fp, fr);
    check("rst_rel_nopress", np, 0);
    check("rst_rel_norel", nr, 0);

    // endurance: 99 clean press/release cycles
    tp = 0; tr = 0; tov = 0;
    for (int i = 0; i < 99; i++) begin
      key_in = 1'b1;
      run(12, np, nr, nov, fp, fr);
      tp += np; tr += nr; tov += nov;
      key_in = 1'b0;
      run(12, np, nr, nov, fp, fr);
      tp += np; tr += nr; tov += nov;
    end
    check("endur_press", tp, 99);
    check("endur_release", tr, 99);
    check("endur_overlap", tov, 0);
    check("endur_level", key_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
